seg7_scan_driver: RTL and testbench

Time-multiplexed scan controller for the board's 2**N-digit seven-segment display. Holds a frame of hex digits accepted over a valid/ready handshake and steps a digit index through every digit at a fixed refresh rate. The index and a strobe drive the anode decoder's select and enable inputs. Per digit, it drives active-low segment and decimal-point patterns, with an inter-digit blanking gap to prevent ghosting.

---
 rtl/seg7_scan_driver_pkg.sv | 18 +
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Frame-load handshake: the producer offers hex nibbles, decimal points and a
// blanking mask; the scan driver accepts on valid && ready.
interface seg7_scan_driver_if #(
  parameter int unsigned N = 3
);
  logic [4*(2**N)-1:0] data_in;
  logic [(2**N)-1:0]   dp_in;
  logic [(2**N)-1:0]   blank_mask;
  logic                data_valid;
  logic                data_ready;

  modport master (
    output data_in,
    output dp_in,
    output blank_mask,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  dp_in,
    input  blank_mask,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan controller with a double-buffered frame,
// per-slot blanking gap and registered active-low outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  seg7_scan_driver_if.slave   bus_if,
  output logic [N-1:0]        digit_sel_o,
  output logic                digit_en_o,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic                frame_start_o
);

  localparam int unsigned Digits = 2**N;
  localparam int unsigned CntW   = $clog2(PRESCALE);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - BLANK_CYCLES - 1);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [N-1:0]          sel_q;
  logic                  en_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  fs_q;

  logic [4*Digits-1:0]   pend_data_q, disp_data_q;
  logic [Digits-1:0]     pend_dp_q, disp_dp_q;
  logic [Digits-1:0]     pend_mask_q, disp_mask_q;
  logic                  pend_full_q;

  logic [3:0]            cur_nib;
  logic [6:0]            hex_seg;
  logic                  cur_mask;
  logic                  cur_dp;
  logic                  frame_wrap;
  logic                  copy_now;
  logic                  capture;

  assign cur_nib  = disp_data_q[{sel_q, 2'b00} +: 4];
  assign cur_mask = disp_mask_q[sel_q];
  assign cur_dp   = disp_dp_q[sel_q];

  hex_to_seg7 u_hex (
    .nibble_i (cur_nib),
    .seg_o    (hex_seg)
  );

  // End of the last digit's SHOW slot: next edge enters digit 0's BLANK.
  assign frame_wrap = enable_i && (state_q == StShow) && (cnt_q == ShowLast) && (sel_q == '1);
  assign copy_now   = pend_full_q && ((state_q == StIdle) || frame_wrap);
  assign capture    = bus_if.data_valid && !pend_full_q;

  assign bus_if.data_ready = ~pend_full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= '0;
      en_q        <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      fs_q        <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_mask_q <= '0;
      pend_full_q <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_mask_q <= '0;
    end else begin
      fs_q <= 1'b0;

      // capture and copy are mutually exclusive: both depend on pend_full_q.
      if (capture) begin
        pend_data_q <= bus_if.data_in;
        pend_dp_q   <= bus_if.dp_in;
        pend_mask_q <= bus_if.blank_mask;
        pend_full_q <= 1'b1;
      end
      if (copy_now) begin
        disp_data_q <= pend_data_q;
        disp_dp_q   <= pend_dp_q;
        disp_mask_q <= pend_mask_q;
        pend_full_q <= 1'b0;
      end

      if (!enable_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        sel_q   <= '0;
        en_q    <= 1'b0;
        seg_q   <= SEG_OFF;
        dp_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StBlank;
            cnt_q   <= '0;
            sel_q   <= '0;
            fs_q    <= 1'b1;
            en_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
          end
          StBlank: begin
            if (cnt_q == BlankLast) begin
              state_q <= StShow;
              cnt_q   <= '0;
              en_q    <= ~cur_mask;
              seg_q   <= cur_mask ? SEG_OFF : hex_seg;
              dp_q    <= ~(cur_dp & ~cur_mask);
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StShow: begin
            if (cnt_q == ShowLast) begin
              state_q <= StBlank;
              cnt_q   <= '0;
              sel_q   <= sel_q + N'(1);
              fs_q    <= frame_wrap;
              en_q    <= 1'b0;
              seg_q   <= SEG_OFF;
              dp_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign digit_sel_o   = sel_q;
  assign digit_en_o    = en_q;
  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a queue holds accepted frames, which a
// small model moves to the display at each frame boundary and checks per cycle.
module tb_seg7_scan_driver;

  localparam int NW     = 2;
  localparam int PRE    = 8;
  localparam int BLK    = 2;
  localparam int FRAME  = PRE * 4;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] digit_sel;
  logic       digit_en;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  frame_t sb[$];
  frame_t disp;
  bit     m_pend_full;
  frame_t none_w;

  logic [6:0] hex_tb [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_driver_if #(.N(NW)) bus_if ();

  seg7_scan_driver #(
    .N            (NW),
    .PRESCALE     (PRE),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .bus_if        (bus_if),
    .digit_sel_o   (digit_sel),
    .digit_en_o    (digit_en),
    .seg_o         (seg),
    .dp_o          (dp),
    .frame_start_o (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " sel"},   16'(digit_sel),          16'h0);
    chk({tag, " en"},    16'(digit_en),           16'h0);
    chk({tag, " seg"},   16'(seg),                16'h7F);
    chk({tag, " dp"},    16'(dp),                 16'h1);
    chk({tag, " fs"},    16'(frame_start),        16'h0);
    chk({tag, " ready"}, 16'(bus_if.data_ready),  16'(!m_pend_full));
  endtask

  task automatic offer(input frame_t w, output bit cap);
    bus_if.data_in    = w.data;
    bus_if.dp_in      = w.dp;
    bus_if.blank_mask = w.mask;
    bus_if.data_valid = 1'b1;
    cap = !m_pend_full;
    if (cap) sb.push_back(w);
  endtask

  // Called right after the edge that entered digit 0's BLANK.
  task automatic run_frame(input int ncyc, input frame_t wa, input int ca,
                           input frame_t wb, input int cb);
    int         s, c;
    logic [1:0] si;
    logic [3:0] nib;
    logic       lit;
    bit         cap, cap2;
    if (m_pend_full) begin
      disp = sb.pop_front();
      m_pend_full = 1'b0;
    end
    for (int i = 0; i < ncyc; i++) begin
      s   = i / PRE;
      c   = i % PRE;
      si  = 2'(s);
      nib = disp.data[{si, 2'b00} +: 4];
      lit = (c >= BLK) && !disp.mask[si];
      chk($sformatf("sel s%0d c%0d", s, c),   16'(digit_sel),   16'(si));
      chk($sformatf("en s%0d c%0d", s, c),    16'(digit_en),    16'(lit));
      chk($sformatf("seg s%0d c%0d", s, c),   16'(seg),         16'(lit ? hex_tb[nib] : 7'h7F));
      chk($sformatf("dp s%0d c%0d", s, c),    16'(dp),          16'(!(lit && disp.dp[si])));
      chk($sformatf("fs s%0d c%0d", s, c),    16'(frame_start), 16'(i == 0));
      chk($sformatf("ready s%0d c%0d", s, c), 16'(bus_if.data_ready), 16'(!m_pend_full));
      cap  = 1'b0;
      cap2 = 1'b0;
      if (i == ca) offer(wa, cap);
      if (i == cb) offer(wb, cap2);
      step();
      bus_if.data_valid = 1'b0;
      if (cap || cap2) m_pend_full = 1'b1;
    end
  endtask

  initial begin
    frame_t w1, w2, w3, w4;
    w1     = '{data: 16'h1A3F, dp: 4'b0010, mask: 4'b0000};
    w2     = '{data: 16'h5B7C, dp: 4'b1000, mask: 4'b0100};
    w3     = '{data: 16'hE6D2, dp: 4'b0101, mask: 4'b0000};
    w4     = '{data: 16'h8049, dp: 4'b0001, mask: 4'b1001};
    none_w = '0;
    disp   = '0;
    m_pend_full = 1'b0;

    rst = 1'b1;
    enable = 1'b0;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = '0;
    bus_if.dp_in      = '0;
    bus_if.blank_mask = '0;
    #1;
    chk_dark("reset");

    #3;
    rst = 1'b0;
    enable = 1'b1;
    step();

    run_frame(FRAME, w1, 3, none_w, -1);       // w1 accepted, ready drops
    run_frame(FRAME, w2, 3, none_w, -1);       // w1 shown: 0E 30 08 79
    run_frame(FRAME, w3, 3, w4, 10);           // w2 masked digit 2; w4 refused
    run_frame(FRAME, w4, 0, none_w, -1);       // w3 shown; w4 accepted right after copy
    run_frame(2 * PRE + 4, none_w, -1, none_w, -1);

    enable = 1'b0;                             // drop mid-SHOW of digit 2
    step();
    chk_dark("idle0");
    step();
    chk_dark("idle1");
    enable = 1'b1;
    step();
    run_frame(FRAME, none_w, -1, none_w, -1);  // restart at digit 0, w4 still shown
    run_frame(PRE + 5, none_w, -1, none_w, -1);

    #2;                                        // between edges, digit 1 in SHOW
    rst = 1'b1;
    #1;
    m_pend_full = 1'b0;
    sb.delete();
    disp = '0;
    chk_dark("async_rst");
    #2;
    rst = 1'b0;
    step();
    run_frame(FRAME, none_w, -1, none_w, -1);  // cleared display: all digits show 0

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
